fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core. It is the producer end of the IF/ID interface that feeds the decode stage.
- Holds the PC, selects the next PC from PCSrcD, PCBranchD and the jump target, and talks to the separate instruction memory (Harvard) with a ready handshake.
- Drives InstrD and PCPlus4D through an IF/ID register with stall and flush.

Parameters:
- Instr_width, 32, instruction word width
- PC_width, 32, PC and address width
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP_INSTR, 32'h0000_0000, bubble encoding (sll $0,$0,0)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- PCSrcD  in  2  {JumpD, BranchD&EqualD} from decode
- PCBranchD  in  PC_width  branch target from decode
- StallF  in  1  hazard unit: hold PC
- StallD  in  1  hazard unit: hold IF/ID
- FlushD  in  1  hazard unit: bubble IF/ID
- ImemReq  out  1  fetch request valid
- ImemAddr  out  PC_width  fetch address, always equals PCF
- ImemRdata  in  Instr_width  instruction; valid when ImemReq&ImemReady
- ImemReady  in  1  memory accepts and returns data this cycle
- PCF  out  PC_width  current fetch PC
- ImemWaitF  out  1  fetch in wait state (to hazard unit)
- InstrD  out  Instr_width  IF/ID instruction
- PCPlus4D  out  PC_width  IF/ID PC+4

Behaviour:
- Reset (async, RST=1): PCF=RESET_PC, state=S_BOOT, holding buffer empty, InstrD=NOP_INSTR, PCPlus4D=0, ImemReq=0, ImemWaitF=0.
- PCPlus4F = PCF+4, modulo 2^PC_width; 32'hFFFF_FFFC wraps to 0.
- JumpTarget = {PCPlus4D[31:28], InstrD[25:0], 2'b00}.
- PCNext by PCSrcD: 00 gives PCPlus4F, 01 gives PCBranchD, 1x gives JumpTarget (jump wins on 11).
- Memory handshake: single-cycle, no outstanding transactions. ImemAddr may change on any cycle.
- S_BOOT: ImemReq=0. Next state is S_FETCH. Gives one idle cycle after reset release.
- S_FETCH: ImemReq=1.
  - Redirect (PCSrcD!=0 && !StallF): PCF<=PCNext regardless of ImemReady; fetched word dropped; stay S_FETCH. FlushD from the hazard unit bubbles IF/ID.
  - ImemReady && !StallF: PCF<=PCNext; IF/ID candidate = {ImemRdata, PCPlus4F}.
  - ImemReady && StallF: latch {ImemRdata, PCPlus4F} into the holding buffer; go S_HOLD; PCF holds.
  - !ImemReady: ImemWaitF=1; PCF holds; IF/ID candidate = {NOP_INSTR, 0}.
- S_HOLD: ImemReq=0; IF/ID candidate = holding buffer.
  - When !StallF: PCF<=PCNext; go S_FETCH.
  - Redirect when !StallF: buffer discarded; go S_FETCH with PCF<=PCNext.
- IF/ID register, in priority order:
  - FlushD: InstrD<=NOP_INSTR, PCPlus4D<=0. Flush beats stall.
  - else StallD: hold.
  - else load the candidate.
- Latency: InstrD shows the word from address A one cycle after the cycle ImemReady is high with PCF=A, given no stall.
- Reset mid-wait or mid-hold: everything returns to reset values at once; the buffer is invalidated.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN
- Defined: adds outputs FetchCnt[31:0] and WaitCnt[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - FetchCnt increments when an instruction is accepted into IF/ID, excluding NOP bubbles and flushed loads.
  - WaitCnt increments every cycle ImemWaitF=1.
- Undefined: these ports and their logic do not exist.

Decomposition:
- Package mips_pkg holds:
  - NOP_INSTR and RESET_PC defaults
  - PCSrc encodings PCSRC_PLUS4=2'b00, PCSRC_BRANCH=2'b01, PCSRC_JUMP=2'b10
  - fetch state enum {S_BOOT, S_FETCH, S_HOLD}
- One sub-module: IF_ID_reg, a parameterised pipeline register with StallD/FlushD enable/clear, instantiated inside fetch_stage.

Test Plan:
- Reset release, ImemReady=1, memory returns addr+32'h100:
  - ImemReq=0 for one cycle, then PCF steps 0,4,8,…
  - InstrD: 32'h100 then 32'h104; PCPlus4D: 4 then 8.
- ImemReady low 3 cycles at PCF=8: ImemWaitF=1 for 3 cycles, PCF stays 8, InstrD=NOP_INSTR for 3 cycles, then 32'h108.
- At PCF=0x10, PCSrcD=01, PCBranchD=0x40, FlushD=1: next PCF=0x40; InstrD=NOP then word@0x40.
- Decode holds j with InstrD[25:0]=26'h10, PCPlus4D=0x1000_0004, PCSrcD=10: PCF becomes 0x1000_0040.
- StallF=StallD=1 for 2 cycles while ImemReady=1 at PCF=0x20: state S_HOLD, ImemReq=0, InstrD unchanged; on release InstrD=word@0x20, PCF=0x24, no duplicate or lost word.
- RST pulse while in S_HOLD: PCF=RESET_PC, InstrD=NOP, S_BOOT. With FETCH_PERF_CNT_EN, counters read 0 after reset.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MIPS pipeline front end.
//
// Contents:
//   DEFAULT_RESET_PC / DEFAULT_NOP_INSTR : default values for the fetch stage
//                                          parameters RESET_PC / NOP_INSTR
//   PCSRC_*                              : encodings of the PCSrcD select
//                                          {JumpD, BranchD & EqualD}
//   fetch_state_e                        : fetch controller states
//   sat_inc32                            : saturating 32-bit increment used by
//                                          the optional performance counters
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/IF_ID_reg.sv
// IF_ID_reg -- IF/ID pipeline register with stall (hold) and flush (bubble).
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   StallD          hold the current contents
//   FlushD          load a bubble {NOP_INSTR, 0}; wins over StallD
//   instr_in        candidate instruction from the fetch stage
//   pc_plus4_in     candidate PC+4 from the fetch stage
//   InstrD          registered instruction to decode
//   PCPlus4D        registered PC+4 to decode
module IF_ID_reg
  import mips_pkg::*;
#(
  parameter int                     Instr_width = 32,
  parameter int                     PC_width    = 32,
  parameter logic [Instr_width-1:0] NOP_INSTR   = DEFAULT_NOP_INSTR
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   StallD,
  input  logic                   FlushD,
  input  logic [Instr_width-1:0] instr_in,
  input  logic [PC_width-1:0]    pc_plus4_in,
  output logic [Instr_width-1:0] InstrD,
  output logic [PC_width-1:0]    PCPlus4D
);

  logic [Instr_width-1:0] instr_d, instr_q;
  logic [PC_width-1:0]    pc_plus4_d, pc_plus4_q;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    if (FlushD) begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = '0;
    end else if (!StallD) begin
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCPlus4D = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage of the pipelined MIPS core.
//
// Holds the PC, selects the next PC (PC+4, branch target or jump target),
// fetches from a single-cycle Harvard instruction memory with a ready
// handshake, and feeds decode through the IF/ID register.
//
// Ports:
//   CLK, RST      clock (rising edge), asynchronous active-high reset
//   PCSrcD        {JumpD, BranchD&EqualD} from decode; jump wins on 2'b11
//   PCBranchD     branch target from decode
//   StallF        hold the PC (hazard unit)
//   StallD        hold IF/ID (hazard unit)
//   FlushD        bubble IF/ID (hazard unit)
//   ImemReq       fetch request valid
//   ImemAddr      fetch address, always equal to PCF
//   ImemRdata     instruction word, valid when ImemReq & ImemReady
//   ImemReady     memory accepts and returns data this cycle
//   PCF           current fetch PC
//   ImemWaitF     fetch waiting on memory (to hazard unit)
//   InstrD        IF/ID instruction
//   PCPlus4D      IF/ID PC+4
//
// Optional build macro FETCH_PERF_CNT_EN adds:
//   FetchCnt      instructions accepted into IF/ID (saturating)
//   WaitCnt       cycles with ImemWaitF=1 (saturating)
module fetch_stage
  import mips_pkg::*;
#(
  parameter int                     Instr_width = 32,
  parameter int                     PC_width    = 32,
  parameter logic [PC_width-1:0]    RESET_PC    = DEFAULT_RESET_PC,
  parameter logic [Instr_width-1:0] NOP_INSTR   = DEFAULT_NOP_INSTR
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             PCSrcD,
  input  logic [PC_width-1:0]    PCBranchD,
  input  logic                   StallF,
  input  logic                   StallD,
  input  logic                   FlushD,
  output logic                   ImemReq,
  output logic [PC_width-1:0]    ImemAddr,
  input  logic [Instr_width-1:0] ImemRdata,
  input  logic                   ImemReady,
  output logic [PC_width-1:0]    PCF,
  output logic                   ImemWaitF,
  output logic [Instr_width-1:0] InstrD,
  output logic [PC_width-1:0]    PCPlus4D
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            FetchCnt,
  output logic [31:0]            WaitCnt
`endif
);

  fetch_state_e           state_d, state_q;
  logic [PC_width-1:0]    pc_d, pc_q;
  logic                   buf_vld_d, buf_vld_q;
  logic [Instr_width-1:0] buf_instr_d, buf_instr_q;
  logic [PC_width-1:0]    buf_pc4_d, buf_pc4_q;

  logic [PC_width-1:0]    pc_plus4_f;
  logic [PC_width-1:0]    jump_target;
  logic [PC_width-1:0]    pc_next;
  logic                   redirect;
  logic [Instr_width-1:0] cand_instr;
  logic [PC_width-1:0]    cand_pc4;

  assign pc_plus4_f  = pc_q + PC_width'(4);
  // Pseudo-direct jump: region bits come from the jump's own PC+4
  assign jump_target = {PCPlus4D[PC_width-1:28], InstrD[25:0], 2'b00};
  // Decode only redirects once the PC is free to move
  assign redirect    = (PCSrcD != PCSRC_PLUS4) && !StallF;

  always_comb begin
    if ((PCSrcD & PCSRC_JUMP) != 2'b00) begin
      pc_next = jump_target;
    end else if (PCSrcD == PCSRC_BRANCH) begin
      pc_next = PCBranchD;
    end else begin
      pc_next = pc_plus4_f;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_vld_d   = buf_vld_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    cand_instr  = NOP_INSTR;
    cand_pc4    = '0;
    ImemReq     = 1'b0;
    ImemWaitF   = 1'b0;

    case (state_q)
      // One idle cycle after reset release before the first request
      S_BOOT: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        ImemReq = 1'b1;
        if (redirect) begin
          // Word fetched from the wrong-path PC is dropped
          pc_d = pc_next;
        end else if (ImemReady && !StallF) begin
          pc_d       = pc_next;
          cand_instr = ImemRdata;
          cand_pc4   = pc_plus4_f;
        end else if (ImemReady) begin
          // Memory delivered while stalled: park the word so it is neither
          // lost nor fetched twice
          buf_vld_d   = 1'b1;
          buf_instr_d = ImemRdata;
          buf_pc4_d   = pc_plus4_f;
          state_d     = S_HOLD;
        end else begin
          ImemWaitF = 1'b1;
        end
      end

      S_HOLD: begin
        if (!redirect && buf_vld_q) begin
          cand_instr = buf_instr_q;
          cand_pc4   = buf_pc4_q;
        end
        if (!StallF) begin
          pc_d      = pc_next;
          buf_vld_d = 1'b0;
          state_d   = S_FETCH;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      buf_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_vld_q <= buf_vld_d;
    end
  end

  // Buffer payload is qualified by buf_vld_q, so it needs no reset
  always_ff @(posedge CLK) begin
    buf_instr_q <= buf_instr_d;
    buf_pc4_q   <= buf_pc4_d;
  end

  assign PCF      = pc_q;
  assign ImemAddr = pc_q;

  IF_ID_reg #(
    .Instr_width (Instr_width),
    .PC_width    (PC_width),
    .NOP_INSTR   (NOP_INSTR)
  ) u_if_id (
    .CLK         (CLK),
    .RST         (RST),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .instr_in    (cand_instr),
    .pc_plus4_in (cand_pc4),
    .InstrD      (InstrD),
    .PCPlus4D    (PCPlus4D)
  );

`ifdef FETCH_PERF_CNT_EN
  logic        cand_vld;
  logic [31:0] fetch_cnt_d, fetch_cnt_q;
  logic [31:0] wait_cnt_d, wait_cnt_q;

  // A real instruction (not a bubble) is on the IF/ID input
  always_comb begin
    case (state_q)
      S_FETCH: cand_vld = !redirect && ImemReady && !StallF;
      S_HOLD:  cand_vld = !redirect && buf_vld_q;
      default: cand_vld = 1'b0;
    endcase
  end

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (cand_vld && !FlushD && !StallD) begin
      fetch_cnt_d = sat_inc32(fetch_cnt_q);
    end
    if (ImemWaitF) begin
      wait_cnt_d = sat_inc32(wait_cnt_q);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_cnt_q <= 32'd0;
      wait_cnt_q  <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign FetchCnt = fetch_cnt_q;
  assign WaitCnt  = wait_cnt_q;
`endif

endmodule
